// File: rtl/sub_eight_serial.sv
// Bit-serial WIDTH-bit subtractor computing dIn0 - dIn1, one bit per clock, LSB first.
// Latency: start sampled on edge k -> done pulses in the cycle after edge k+WIDTH.
// Backpressure: none; start is ignored while busy, and dropping enable aborts a run.
//
// Ports:
//   clk, rstN     clock and asynchronous active-low reset
//   start, enable request (taken in IDLE/DONE) and unit enable (gates outputs)
//   dIn0, dIn1    minuend and subtrahend, captured when a request is accepted
//   busy, done    run indicator and one-cycle completion pulse
//   dOut, bOut    difference and final borrow, held between ops, ANDed with enable
module sub_eight_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             start,
  input  logic             enable,
  input  logic [WIDTH-1:0] dIn0,
  input  logic [WIDTH-1:0] dIn1,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dOut,
  output logic             bOut
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic            brw_q, brw_d;
  logic            bout_q, bout_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic bit_a, bit_b, diff_bit, brw_nx;

  // One full-subtractor slice evaluated on the current bit position.
  always_comb begin
    bit_a    = a_q[idx_q];
    bit_b    = b_q[idx_q];
    diff_bit = bit_a ^ bit_b ^ brw_q;
    brw_nx   = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & brw_q);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    brw_d   = brw_q;
    idx_d   = idx_q;
    dout_d  = dout_q;
    bout_d  = bout_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      // DONE shares IDLE's accept logic so a held start chains ops with no gap.
      IDLE, DONE: begin
        if (start && enable) begin
          a_d     = dIn0;
          b_d     = dIn1;
          res_d   = '0;
          brw_d   = 1'b0;
          idx_d   = '0;
          state_d = RUN;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (!enable) begin
          // Abort: published result/borrow registers are left untouched.
          state_d = IDLE;
        end else begin
          res_d[idx_q] = diff_bit;
          brw_d        = brw_nx;
          if (idx_q == LAST_IDX) begin
            dout_d  = res_d;
            bout_d  = brw_nx;
            idx_d   = '0;
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            idx_d  = idx_q + 1'b1;
            busy_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      brw_q   <= 1'b0;
      idx_q   <= '0;
      dout_q  <= '0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      brw_q   <= brw_d;
      idx_q   <= idx_d;
      dout_q  <= dout_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign dOut = dout_q & {WIDTH{enable}};
  assign bOut = bout_q & enable;

endmodule

// File: tb/tb_sub_eight_serial.sv
// Directed and random checks of the bit-serial subtractor.
// Inputs are driven around the falling edge or 1ns after the rising edge.
// Outputs are sampled 1ns after the rising edge, away from the active edge.
module tb_sub_eight_serial;

  logic       clk;
  logic       rstN;
  logic       start;
  logic       enable;
  logic [7:0] dIn0;
  logic [7:0] dIn1;
  logic       busy;
  logic       done;
  logic [7:0] dOut;
  logic       bOut;

  int total;
  int bad;

  sub_eight_serial #(.WIDTH(8)) dut (
    .clk   (clk),
    .rstN  (rstN),
    .start (start),
    .enable(enable),
    .dIn0  (dIn0),
    .dIn1  (dIn1),
    .busy  (busy),
    .done  (done),
    .dOut  (dOut),
    .bOut  (bOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a one-cycle start request; returns 1ns after the sampling edge.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    dIn0  = a;
    dIn1  = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Count rising edges until done is seen, bounded.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  // Count done pulses over a fixed number of cycles.
  task automatic count_done(input int cycles, output int dn);
    dn = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (done) dn++;
    end
  endtask

  logic [7:0] va [4] = '{8'h05, 8'h03, 8'h00, 8'h80};
  logic [7:0] vb [4] = '{8'h03, 8'h05, 8'h01, 8'h80};
  logic [7:0] vd [4] = '{8'h02, 8'hFE, 8'hFF, 8'h00};
  logic       vbr[4] = '{1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    int n;
    int dn;
    logic [7:0] ra, rb;
    logic [8:0] ref9;

    total  = 0;
    bad    = 0;
    rstN   = 1'b0;
    start  = 1'b0;
    enable = 1'b1;
    dIn0   = '0;
    dIn1   = '0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dout", dOut, 0);
    check("rst_bout", bOut, 0);
    @(negedge clk);
    rstN = 1'b1;

    // Directed vectors, latency and one-cycle done.
    for (int i = 0; i < 4; i++) begin
      start_op(va[i], vb[i]);
      check("busy_run", busy, 1);
      wait_done(n);
      check("latency", n, 8);
      check("dout", dOut, vd[i]);
      check("bout", bOut, vbr[i]);
      check("busy_done", busy, 0);
      @(posedge clk);
      #1;
      check("done_pulse", done, 0);
    end

    // Start while disabled in IDLE is ignored.
    enable = 1'b0;
    start_op(8'h44, 8'h11);
    check("dis_start_busy", busy, 0);
    enable = 1'b1;

    // Start re-pulsed mid-run with new operands is ignored.
    start_op(8'h05, 8'h03);
    @(posedge clk); #1;
    @(posedge clk); #1;
    dIn0  = 8'hFF;
    dIn1  = 8'h01;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n);
    check("repulse_lat", n, 5);
    check("repulse_dout", dOut, 8'h02);
    check("repulse_bout", bOut, 0);
    count_done(12, dn);
    check("repulse_once", dn, 0);
    check("repulse_idle", busy, 0);

    // Enable dropped mid-run aborts; prior result reappears afterwards.
    start_op(8'h10, 8'h01);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    enable = 1'b0;
    #1;
    check("gate_dout", dOut, 0);
    @(posedge clk); #1;
    check("abort_busy", busy, 0);
    count_done(12, dn);
    check("abort_nodone", dn, 0);
    check("abort_dout0", dOut, 0);
    enable = 1'b1;
    #1;
    check("abort_keep", dOut, 8'h02);
    check("abort_keepb", bOut, 0);

    // Asynchronous reset mid-run clears outputs before the next edge.
    start_op(8'h03, 8'h05);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstN = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_dout", dOut, 0);
    check("arst_bout", bOut, 0);
    @(negedge clk);
    rstN = 1'b1;
    count_done(12, dn);
    check("arst_nodone", dn, 0);
    check("arst_idle", busy, 0);

    // Start held high through DONE chains a second op with no idle gap.
    @(negedge clk);
    dIn0  = 8'h20;
    dIn1  = 8'h30;
    start = 1'b1;
    @(posedge clk); #1;
    dIn0 = 8'h7F;
    dIn1 = 8'h0F;
    wait_done(n);
    check("b2b_lat1", n, 8);
    check("b2b_dout1", dOut, 8'hF0);
    check("b2b_bout1", bOut, 1);
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_busy", busy, 1);
    check("b2b_done0", done, 0);
    n = 1;
    while (!done && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("b2b_gap", n, 9);
    check("b2b_dout2", dOut, 8'h70);
    check("b2b_bout2", bOut, 0);

    // Random operands against an arithmetic model.
    for (int i = 0; i < 1000; i++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      ref9 = {1'b0, ra} - {1'b0, rb};
      start_op(ra, rb);
      wait_done(n);
      check("rnd_dout", dOut, ref9[7:0]);
      check("rnd_bout", bOut, ref9[8]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
